// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t     : receiver FSM states
//   RX_SYNC_STAGES : flops in the rx line synchroniser
//   MIN_BAUD_DIV   : smallest clocks-per-bit value the receiver works with
package uart_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam int RX_SYNC_STAGES = 2;
  localparam int MIN_BAUD_DIV   = 4;

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   wr_en_i       : write request (accepted when not full, or when popping while full)
//   wdata_i       : write data
//   rd_en_i       : pop head (ignored while empty)
//   rdata_o       : head entry, 0 while empty
//   full_o        : all entries occupied
//   empty_o       : no entries
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  wr_en_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  rd_en_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           count;
  logic                  wr_ok;
  logic                  rd_ok;

  assign full_o  = (count == (AW+1)'(FIFO_DEPTH));
  assign empty_o = (count == '0);

  // A pop in the same cycle frees the slot, so a write into a full FIFO
  // still succeeds when the host is reading.
  assign rd_ok = rd_en_i & ~empty_o;
  assign wr_ok = wr_en_i & (~full_o | rd_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
    end
  end

  // Storage needs no reset: entries are only visible once counted.
  always_ff @(posedge clk_i) begin
    if (wr_ok) mem[wr_ptr] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: line synchroniser, start-bit validation, mid-bit
// sampling and a FWFT receive FIFO.
// Ports:
//   clk_i, rst_ni : clock, async active-low reset
//   rx_en_i       : allow a new frame to start (an active frame always completes)
//   baud_div_i    : clocks per bit period (>= 4, stable while busy_o)
//   rx_bit_i      : asynchronous serial line, idle high
//   rx_re_i       : pop FIFO head
//   dout_o        : FIFO head, valid while empty_o=0
//   full_o/empty_o: FIFO status
//   frame_err_o   : 1-cycle pulse, stop bit sampled low
//   overrun_o     : 1-cycle pulse, good byte dropped because the FIFO was full
//   busy_o        : receiver FSM not idle
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_en_i,
  input  logic [15:0]           baud_div_i,
  input  logic                  rx_bit_i,
  input  logic                  rx_re_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic                  frame_err_o,
  output logic                  overrun_o,
  output logic                  busy_o
);

  localparam int BW = $clog2(DATA_WIDTH);

  rx_state_t             state, state_n;
  logic [15:0]           cnt, cnt_n;
  logic [BW-1:0]         bit_cnt, bit_cnt_n;
  logic [DATA_WIDTH-1:0] sh, sh_n;

  logic [RX_SYNC_STAGES-1:0] sync;
  logic                      rx_s;
  logic                      rx_q;
  logic                      fall;

  logic [15:0] half;
  logic        baud_ok;
  logic        bit_end;
  logic        stop_good, stop_bad;
  logic        wr_req_q;
  logic        ferr_q;

  // Synchroniser and edge detector; idle-high reset value avoids a false
  // start edge when reset is released.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync <= '1;
      rx_q <= 1'b1;
    end else begin
      sync <= {sync[RX_SYNC_STAGES-2:0], rx_bit_i};
      rx_q <= rx_s;
    end
  end

  assign rx_s    = sync[RX_SYNC_STAGES-1];
  assign fall    = rx_q & ~rx_s;
  assign half    = baud_div_i >> 1;
  assign baud_ok = (baud_div_i >= 16'(MIN_BAUD_DIV));
  assign bit_end = (cnt == baud_div_i - 16'd1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_cnt <= bit_cnt_n;
      sh      <= sh_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 16'd1;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    stop_good = 1'b0;
    stop_bad  = 1'b0;
    unique case (state)
      RX_IDLE: begin
        cnt_n = '0;
        if (fall && rx_en_i && baud_ok) state_n = RX_START;
      end
      RX_START: begin
        // Re-check the line half a bit in; a high level means a glitch.
        if (cnt == half - 16'd1) begin
          cnt_n     = '0;
          bit_cnt_n = '0;
          state_n   = rx_s ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (bit_end) begin
          cnt_n     = '0;
          sh_n      = {rx_s, sh[DATA_WIDTH-1:1]};
          bit_cnt_n = bit_cnt + BW'(1);
          if (bit_cnt == BW'(DATA_WIDTH - 1)) state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        // Leaving at the stop-bit midpoint gives half a bit of margin to
        // catch the next start edge. A held-low line yields no new fall,
        // so a break produces a single framing error.
        if (bit_end) begin
          cnt_n     = '0;
          state_n   = RX_IDLE;
          stop_good = rx_s;
          stop_bad  = ~rx_s;
        end
      end
      default: begin
        state_n = RX_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // The stop-bit result is acted on one cycle later; whether the byte
  // fits is decided in that write cycle so a simultaneous pop can make room.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_req_q <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      wr_req_q <= stop_good;
      ferr_q   <= stop_bad;
    end
  end

  assign frame_err_o = ferr_q;
  assign overrun_o   = wr_req_q & full_o & ~rx_re_i;
  assign busy_o      = (state != RX_IDLE);

  uart_rx_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .wr_en_i(wr_req_q),
    .wdata_i(sh),
    .rd_en_i(rx_re_i),
    .rdata_o(dout_o),
    .full_o (full_o),
    .empty_o(empty_o)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx: serial frames are driven bit by bit on
// rx_bit_i and the FIFO read port, status and pulse outputs are checked
// against hand-computed values.
module tb_uart_rx;

  logic        clk;
  logic        rst_n;
  logic        rx_en;
  logic [15:0] div;
  logic        rx_bit;
  logic        rx_re;
  logic [7:0]  dout;
  logic        full;
  logic        empty;
  logic        ferr;
  logic        ovr;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int ferr_cnt  = 0;
  int ovr_cnt   = 0;
  int efall_cnt = 0;
  logic empty_q = 1'b1;

  uart_rx #(.DATA_WIDTH(8), .FIFO_DEPTH(16)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rx_en_i    (rx_en),
    .baud_div_i (div),
    .rx_bit_i   (rx_bit),
    .rx_re_i    (rx_re),
    .dout_o     (dout),
    .full_o     (full),
    .empty_o    (empty),
    .frame_err_o(ferr),
    .overrun_o  (ovr),
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse and edge counters, sampled on the inactive edge.
  always @(negedge clk) begin
    if (ferr) ferr_cnt <= ferr_cnt + 1;
    if (ovr) ovr_cnt <= ovr_cnt + 1;
    if (empty_q && !empty) efall_cnt <= efall_cnt + 1;
    empty_q <= empty;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (int'(div)) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_bit = b[i];
      repeat (int'(div)) @(negedge clk);
    end
    rx_bit = stop_bit;
    repeat (int'(div)) @(negedge clk);
    rx_bit = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rx_re = 1'b1;
    @(negedge clk);
    rx_re = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    rx_en  = 1'b1;
    div    = 16'd104;
    rx_bit = 1'b1;
    rx_re  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full",  32'(full),  32'd0);
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_dout",  32'(dout),  32'h00);
    check("rst_ferr",  32'(ferr),  32'd0);
    check("rst_ovr",   32'(ovr),   32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1. Single good frame 0xA5
    send_frame(8'hA5, 1'b1);
    repeat (4) @(negedge clk);
    check("t1_dout",   32'(dout),  32'hA5);
    check("t1_empty",  32'(empty), 32'd0);
    check("t1_efall",  32'(efall_cnt), 32'd1);
    check("t1_flags",  32'(ferr_cnt + ovr_cnt), 32'd0);
    check("t1_busy",   32'(busy),  32'd0);
    pop();
    check("t1_popped", 32'(empty), 32'd1);
    check("t1_dout0",  32'(dout),  32'h00);

    // 2. 20-clock glitch is rejected at the half-bit check
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (20) @(negedge clk);
    rx_bit = 1'b1;
    check("t2_busy_mid", 32'(busy), 32'd1);
    repeat (100) @(negedge clk);
    check("t2_busy",  32'(busy),  32'd0);
    check("t2_empty", 32'(empty), 32'd1);
    check("t2_flags", 32'(ferr_cnt + ovr_cnt), 32'd0);

    // rx_en low blocks frame start
    rx_en = 1'b0;
    send_frame(8'h5A, 1'b1);
    repeat (4) @(negedge clk);
    check("en_empty", 32'(empty), 32'd1);
    check("en_busy",  32'(busy),  32'd0);
    rx_en = 1'b1;

    // 3. Stop bit forced low
    send_frame(8'h3C, 1'b0);
    repeat (4) @(negedge clk);
    check("t3_ferr",  32'(ferr_cnt), 32'd1);
    check("t3_empty", 32'(empty),    32'd1);
    check("t3_ovr",   32'(ovr_cnt),  32'd0);

    // Break: line low for three frame lengths gives exactly one framing error
    @(negedge clk);
    rx_bit = 1'b0;
    repeat (3 * 10 * 104) @(negedge clk);
    check("brk_idle", 32'(busy), 32'd0);
    rx_bit = 1'b1;
    repeat (10) @(negedge clk);
    check("brk_ferr",  32'(ferr_cnt), 32'd2);
    check("brk_empty", 32'(empty),    32'd1);

    // 4. Fill FIFO, overflow with 0x10, drain in order
    div = 16'd16;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 16; i++) send_frame(8'(i), 1'b1);
    repeat (4) @(negedge clk);
    check("t4_full",   32'(full),    32'd1);
    check("t4_ovr0",   32'(ovr_cnt), 32'd0);
    send_frame(8'h10, 1'b1);
    repeat (4) @(negedge clk);
    check("t4_ovr1",   32'(ovr_cnt), 32'd1);
    check("t4_full2",  32'(full),    32'd1);
    check("t4_ferr",   32'(ferr_cnt), 32'd2);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t4_drain%0d", i), 32'(dout), 32'(i));
      pop();
    end
    check("t4_empty", 32'(empty), 32'd1);
    check("t4_nfull", 32'(full),  32'd0);

    // 5. Reset during bit 4 of 0xFF, then 0x12
    fork
      send_frame(8'hFF, 1'b1);
      begin
        @(negedge rx_bit);
        repeat (16 * 5 + 8) @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t5_rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
      end
    join
    repeat (4) @(negedge clk);
    check("t5_empty0", 32'(empty), 32'd1);
    send_frame(8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("t5_dout",  32'(dout),  32'h12);
    pop();
    check("t5_empty", 32'(empty), 32'd1);
    check("t5_flags", 32'(ferr_cnt + ovr_cnt), 32'd3);

    // 6. Full FIFO, pop in the write cycle of the 17th byte
    for (int i = 0; i < 16; i++) send_frame(8'h80 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    check("t6_full", 32'(full), 32'd1);
    fork
      send_frame(8'h90, 1'b1);
      begin
        @(negedge rx_bit);
        repeat (3 + 8 + 9 * 16) @(posedge clk);
        @(negedge clk);
        rx_re = 1'b1;
        @(negedge clk);
        rx_re = 1'b0;
      end
    join
    repeat (4) @(negedge clk);
    check("t6_ovr",   32'(ovr_cnt), 32'd1);
    check("t6_full2", 32'(full),    32'd1);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t6_drain%0d", i), 32'(dout), 32'h81 + 32'(i));
      pop();
    end
    check("t6_empty", 32'(empty), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
